// File: rtl/mem_if_pkg.sv
// Shared widths, state encoding and line type for the cache-line / bmem adapter.
package mem_if_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int ADDR_W  = 32;
  localparam int BEATS   = LINE_W / BURST_W;
  localparam int OFF_W   = $clog2(LINE_W / 8);
  localparam int BEAT_W  = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_DATA  = 3'd2,
    WR_BURST = 3'd3,
    RESP     = 3'd4
  } adapter_state_t;

  typedef logic [LINE_W-1:0] line_t;

  // Clear the byte-offset bits so the address points at the start of its line.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_mem_adapter_chk.sv
// Simulation-only protocol checker for the dfp side of the adapter.
module cacheline_mem_adapter_chk (
  input logic clk,
  input logic rst,
  input logic idle,
  input logic dfp_read,
  input logic dfp_write
);

  // Simultaneous read and write is illegal; the adapter services the write and drops the read.
  always @(posedge clk) begin
    if (!rst && idle) begin
      assert (!(dfp_read && dfp_write))
        else $warning("dfp_read and dfp_write asserted together: write serviced, read dropped");
    end
  end

endmodule

// File: rtl/cacheline_mem_adapter.sv
// Responder for 256-bit dfp line requests; turns each one into a 4-beat, 64-bit bmem burst
// and assembles returning read beats into a full line.
module cacheline_mem_adapter
  import mem_if_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  dfp_addr,
  input  logic               dfp_read,
  input  logic               dfp_write,
  input  logic [LINE_W-1:0]  dfp_wdata,
  output logic [LINE_W-1:0]  dfp_rdata,
  output logic               dfp_resp,
  output logic [ADDR_W-1:0]  bmem_addr,
  output logic               bmem_read,
  output logic               bmem_write,
  output logic [BURST_W-1:0] bmem_wdata,
  input  logic               bmem_ready,
  input  logic [ADDR_W-1:0]  bmem_raddr,
  input  logic [BURST_W-1:0] bmem_rdata,
  input  logic               bmem_rvalid
);

  adapter_state_t      state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   line_addr_q, line_addr_d;
  line_t               wbuf_q, wbuf_d;
  line_t               line_buf_q, line_buf_d;
  line_t               dfp_rdata_q, dfp_rdata_d;
  logic                dfp_resp_q, dfp_resp_d;
  logic [ADDR_W-1:0]   bmem_addr_q, bmem_addr_d;
  logic                bmem_read_q, bmem_read_d;
  logic                bmem_write_q, bmem_write_d;
  logic [BURST_W-1:0]  bmem_wdata_q, bmem_wdata_d;
  logic                beat_hit_s;

  // Byte-offset bits of the request address are dropped by line alignment.
  logic unused_addr_bits;
  assign unused_addr_bits = ^dfp_addr[OFF_W-1:0];

  // A returning beat belongs to this burst only if its tag matches the latched line.
  assign beat_hit_s = bmem_rvalid && (bmem_raddr == line_addr_q);

  // Next-state, buffer and output computation; outputs are derived from the next state
  // so that every port comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    line_addr_d = line_addr_q;
    wbuf_d      = wbuf_q;
    line_buf_d  = line_buf_q;
    dfp_rdata_d = dfp_rdata_q;

    case (state_q)
      IDLE: begin
        if (dfp_write) begin
          // Write wins over a simultaneous (illegal) read.
          state_d     = WR_BURST;
          line_addr_d = line_align(dfp_addr);
          wbuf_d      = dfp_wdata;
          beat_d      = 2'd0;
        end else if (dfp_read) begin
          state_d     = RD_REQ;
          line_addr_d = line_align(dfp_addr);
          beat_d      = 2'd0;
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        if (bmem_ready) begin
          state_d = RD_DATA;
          beat_d  = 2'd0;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_DATA: begin
        if (beat_hit_s) begin
          line_buf_d[{beat_q, 6'd0} +: BURST_W] = bmem_rdata;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d     = RESP;
            dfp_rdata_d = line_buf_d;
          end else begin
            state_d = RD_DATA;
          end
        end else begin
          state_d = RD_DATA;
        end
      end
      WR_BURST: begin
        if (bmem_ready) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = RESP;
          end else begin
            state_d = WR_BURST;
          end
        end else begin
          state_d = WR_BURST;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        beat_d  = 2'd0;
      end
    endcase

    dfp_resp_d   = (state_d == RESP);
    bmem_read_d  = (state_d == RD_REQ);
    bmem_write_d = (state_d == WR_BURST);
    if ((state_d == RD_REQ) || (state_d == WR_BURST)) begin
      bmem_addr_d = line_addr_d;
    end else begin
      bmem_addr_d = {ADDR_W{1'b0}};
    end
    if (state_d == WR_BURST) begin
      bmem_wdata_d = wbuf_d[{beat_d, 6'd0} +: BURST_W];
    end else begin
      bmem_wdata_d = {BURST_W{1'b0}};
    end
  end

  // State, buffers and registered outputs; synchronous reset aborts any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= 2'd0;
      line_addr_q  <= {ADDR_W{1'b0}};
      wbuf_q       <= {LINE_W{1'b0}};
      line_buf_q   <= {LINE_W{1'b0}};
      dfp_rdata_q  <= {LINE_W{1'b0}};
      dfp_resp_q   <= 1'b0;
      bmem_addr_q  <= {ADDR_W{1'b0}};
      bmem_read_q  <= 1'b0;
      bmem_write_q <= 1'b0;
      bmem_wdata_q <= {BURST_W{1'b0}};
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      line_addr_q  <= line_addr_d;
      wbuf_q       <= wbuf_d;
      line_buf_q   <= line_buf_d;
      dfp_rdata_q  <= dfp_rdata_d;
      dfp_resp_q   <= dfp_resp_d;
      bmem_addr_q  <= bmem_addr_d;
      bmem_read_q  <= bmem_read_d;
      bmem_write_q <= bmem_write_d;
      bmem_wdata_q <= bmem_wdata_d;
    end
  end

  assign dfp_rdata  = dfp_rdata_q;
  assign dfp_resp   = dfp_resp_q;
  assign bmem_addr  = bmem_addr_q;
  assign bmem_read  = bmem_read_q;
  assign bmem_write = bmem_write_q;
  assign bmem_wdata = bmem_wdata_q;

  cacheline_mem_adapter_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .idle      (state_q == IDLE),
    .dfp_read  (dfp_read),
    .dfp_write (dfp_write)
  );

endmodule

// File: tb/tb_cacheline_mem_adapter.sv
// Directed, table-driven bench for cacheline_mem_adapter.
module tb_cacheline_mem_adapter;

  logic         clk;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int checks = 0;
  int errors = 0;
  int wr_beats = 0;
  int rd_seen = 0;

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] D0 = 64'hD0D0_0000_0000_00D0;
  localparam logic [63:0] D1 = 64'hD1D1_0000_0000_00D1;
  localparam logic [63:0] D2 = 64'hD2D2_0000_0000_00D2;
  localparam logic [63:0] D3 = 64'hD3D3_0000_0000_00D3;

  cacheline_mem_adapter dut (
    .clk         (clk),
    .rst         (rst),
    .dfp_addr    (dfp_addr),
    .dfp_read    (dfp_read),
    .dfp_write   (dfp_write),
    .dfp_wdata   (dfp_wdata),
    .dfp_rdata   (dfp_rdata),
    .dfp_resp    (dfp_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted write beats and cycles with a read command outstanding.
  always @(posedge clk) begin
    if (!rst && bmem_write && bmem_ready) wr_beats <= wr_beats + 1;
    if (!rst && bmem_read) rd_seen <= rd_seen + 1;
  end

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wd;
    logic         rdy;
    logic         rv;
    logic [31:0]  ra;
    logic [63:0]  rdt;
    logic         e_resp;
    logic         e_rd;
    logic         e_wr;
    logic [31:0]  e_addr;
    logic [63:0]  e_wd;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [255:0] wd, input logic rdy, input logic rv,
                              input logic [31:0] ra, input logic [63:0] rdt,
                              input logic er, input logic erd, input logic ewr,
                              input logic [31:0] ea, input logic [63:0] ewd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.rdy = rdy; v.rv = rv;
    v.ra = ra; v.rdt = rdt; v.e_resp = er; v.e_rd = erd; v.e_wr = ewr;
    v.e_addr = ea; v.e_wd = ewd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic cyc(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [255:0] wd, input logic rdy, input logic rv,
                     input logic [31:0] ra, input logic [63:0] rdt);
    @(negedge clk);
    dfp_read = rd; dfp_write = wr; dfp_addr = addr; dfp_wdata = wd;
    bmem_ready = rdy; bmem_rvalid = rv; bmem_raddr = ra; bmem_rdata = rdt;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_resp"},  {255'd0, dfp_resp}, 256'd0);
    chk({tag, "_read"},  {255'd0, bmem_read}, 256'd0);
    chk({tag, "_write"}, {255'd0, bmem_write}, 256'd0);
    chk({tag, "_addr"},  {224'd0, bmem_addr}, 256'd0);
    chk({tag, "_wdata"}, {192'd0, bmem_wdata}, 256'd0);
    chk({tag, "_rdata"}, dfp_rdata, 256'd0);
  endtask

  initial begin
    logic [255:0] w_line, rd_line, n_line, c_line, e_line;
    logic [63:0]  nb[4];
    logic [63:0]  cb[4];
    logic [63:0]  eb[4];

    w_line  = {D3, D2, D1, D0};
    rd_line = {B4, B3, B2, B1};
    nb[0] = 64'hA000_0000_0000_0001; nb[1] = 64'hA000_0000_0000_0002;
    nb[2] = 64'hA000_0000_0000_0003; nb[3] = 64'hA000_0000_0000_0004;
    n_line = {nb[3], nb[2], nb[1], nb[0]};
    cb[0] = 64'hC0C0_C0C0_0000_0000; cb[1] = 64'hC1C1_C1C1_0000_0001;
    cb[2] = 64'hC2C2_C2C2_0000_0002; cb[3] = 64'hC3C3_C3C3_0000_0003;
    c_line = {cb[3], cb[2], cb[1], cb[0]};
    eb[0] = 64'hE0E0_0000_1111_0000; eb[1] = 64'hE1E1_0000_1111_0001;
    eb[2] = 64'hE2E2_0000_1111_0002; eb[3] = 64'hE3E3_0000_1111_0003;
    e_line = {eb[3], eb[2], eb[1], eb[0]};

    // Basic read at 0x1024 then stalled write at 0x2000.
    vecs[0]  = mk(1'b1, 1'b0, 32'h1024, 256'd0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 1'b0, 32'h1020, 64'h0);
    vecs[1]  = mk(1'b0, 1'b0, 32'h0, 256'd0, 1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    vecs[2]  = mk(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b1, 32'h1020, B1, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b1, 32'h1020, B2, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    vecs[4]  = mk(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b1, 32'h1020, B3, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    vecs[5]  = mk(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b1, 32'h1020, B4, 1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
    vecs[6]  = mk(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    vecs[7]  = mk(1'b0, 1'b1, 32'h2000, w_line, 1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1, 32'h2000, D0);
    vecs[8]  = mk(1'b0, 1'b0, 32'h0, 256'd0, 1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1, 32'h2000, D1);
    vecs[9]  = mk(1'b1, 1'b0, 32'h3000, 256'd0, 1'b0, 1'b1, 32'h2000, 64'hEEEE, 1'b0, 1'b0, 1'b1, 32'h2000, D1);
    vecs[10] = mk(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1, 32'h2000, D1);
    vecs[11] = mk(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1, 32'h2000, D1);
    vecs[12] = mk(1'b0, 1'b0, 32'h0, 256'd0, 1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1, 32'h2000, D2);
    vecs[13] = mk(1'b0, 1'b0, 32'h0, 256'd0, 1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1, 32'h2000, D3);
    vecs[14] = mk(1'b0, 1'b0, 32'h0, 256'd0, 1'b1, 1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
    vecs[15] = mk(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);

    rst = 1'b1;
    dfp_read = 1'b0; dfp_write = 1'b0; dfp_addr = 32'h0; dfp_wdata = 256'd0;
    bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_raddr = 32'h0; bmem_rdata = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    wr_beats = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].rdy, vecs[i].rv, vecs[i].ra, vecs[i].rdt);
      chk($sformatf("v%0d_resp", i),  {255'd0, dfp_resp},   {255'd0, vecs[i].e_resp});
      chk($sformatf("v%0d_read", i),  {255'd0, bmem_read},  {255'd0, vecs[i].e_rd});
      chk($sformatf("v%0d_write", i), {255'd0, bmem_write}, {255'd0, vecs[i].e_wr});
      if (vecs[i].e_rd || vecs[i].e_wr) chk($sformatf("v%0d_addr", i), {224'd0, bmem_addr}, {224'd0, vecs[i].e_addr});
      if (vecs[i].e_wr) chk($sformatf("v%0d_wdata", i), {192'd0, bmem_wdata}, {192'd0, vecs[i].e_wd});
      if (i == 5) chk("basic_read_line", dfp_rdata, rd_line);
    end
    chk("stalled_write_beats", 256'(wr_beats), 256'd4);
    chk("write_keeps_rdata", dfp_rdata, rd_line);

    // Noisy read at 0x3058 (line 0x3040): stalled request, gaps, one foreign beat.
    cyc(1'b1, 1'b0, 32'h3058, 256'd0, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("noisy_req_addr", {224'd0, bmem_addr}, {224'd0, 32'h3040});
    cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b1, 32'h3040, 64'hDEAD);
    chk("noisy_req_hold1", {255'd0, bmem_read}, 256'd1);
    cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("noisy_req_hold2", {255'd0, bmem_read}, 256'd1);
    cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b1, 1'b0, 32'h0, 64'h0);
    chk("noisy_req_drop", {255'd0, bmem_read}, 256'd0);
    cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b1, 32'h3040, nb[0]);
    cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b0, 32'h0, 64'h0);
    cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b1, 32'h3040, nb[1]);
    cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b1, 32'h3000, 64'hBADB_AD00_BADB_AD00);
    cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b1, 32'h3040, nb[2]);
    chk("noisy_no_early_resp", {255'd0, dfp_resp}, 256'd0);
    cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b0, 32'h0, 64'h0);
    cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b1, 32'h3040, nb[3]);
    chk("noisy_resp", {255'd0, dfp_resp}, 256'd1);
    chk("noisy_line", dfp_rdata, n_line);
    cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("noisy_resp_one_cycle", {255'd0, dfp_resp}, 256'd0);

    // Reset after two beats of a read at 0x500; late beats land in IDLE.
    cyc(1'b1, 1'b0, 32'h0500, 256'd0, 1'b0, 1'b0, 32'h0, 64'h0);
    cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b1, 1'b0, 32'h0, 64'h0);
    cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b1, 32'h0500, 64'h5);
    cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b1, 32'h0500, 64'h6);
    @(negedge clk);
    rst = 1'b1;
    bmem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b1, 32'h0500, 64'h7);
    chk("midrst_late1_resp", {255'd0, dfp_resp}, 256'd0);
    cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b1, 32'h0500, 64'h8);
    chk("midrst_late2_resp", {255'd0, dfp_resp}, 256'd0);
    chk("midrst_rdata", dfp_rdata, 256'd0);

    // Read at 0x40 after the abort, then a write captured the cycle after RESP.
    cyc(1'b1, 1'b0, 32'h0040, 256'd0, 1'b1, 1'b0, 32'h0, 64'h0);
    chk("rd40_addr", {224'd0, bmem_addr}, {224'd0, 32'h40});
    cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b1, 1'b0, 32'h0, 64'h0);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b1, 32'h0040, cb[k]);
    chk("rd40_resp", {255'd0, dfp_resp}, 256'd1);
    chk("rd40_line", dfp_rdata, c_line);
    cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b0, 32'h0, 64'h0);
    cyc(1'b0, 1'b1, 32'h0060, e_line, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("b2b_write", {255'd0, bmem_write}, 256'd1);
    chk("b2b_addr", {224'd0, bmem_addr}, {224'd0, 32'h60});
    chk("b2b_wdata0", {192'd0, bmem_wdata}, {192'd0, eb[0]});
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b1, 1'b0, 32'h0, 64'h0);
      if (k < 3) chk($sformatf("b2b_wdata%0d", k + 1), {192'd0, bmem_wdata}, {192'd0, eb[k + 1]});
    end
    chk("b2b_resp", {255'd0, dfp_resp}, 256'd1);
    chk("b2b_keeps_rdata", dfp_rdata, c_line);

    // Illegal dual request at 0x80: write serviced, no read command.
    cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b0, 1'b0, 32'h0, 64'h0);
    rd_seen = 0;
    cyc(1'b1, 1'b1, 32'h0080, w_line, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("dual_write", {255'd0, bmem_write}, 256'd1);
    chk("dual_no_read", {255'd0, bmem_read}, 256'd0);
    chk("dual_addr", {224'd0, bmem_addr}, {224'd0, 32'h80});
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 32'h0, 256'd0, 1'b1, 1'b0, 32'h0, 64'h0);
    chk("dual_resp", {255'd0, dfp_resp}, 256'd1);
    chk("dual_read_cycles", 256'(rd_seen), 256'd0);
    chk("dual_keeps_rdata", dfp_rdata, c_line);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
